load_branch_arbiter: RTL and testbench

LOAD_BRANCH_ARBITER -- requirements
Module: load_branch_arbiter

---
 rtl/load_branch_arbiter.sv | 150 +++++++++++++++
 tb/tb_load_branch_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/load_branch_arbiter.sv
// load_branch_arbiter
//   Round-robin arbiter that hands one shared, buffered driver net to one of
//   N_LOADS load branches at a time. Each grant is followed by a one-cycle
//   turnaround with the driver disabled (break-before-make) and one IDLE
//   cycle in which the next winner is chosen.
//
// Ports
//   clk          : clock, all state updates on the rising edge
//   rst_n        : asynchronous, active-low reset
//   req[N]       : per-branch request
//   done[N]      : early-release strobe, honoured only for the granted branch
//   gnt[N]       : one-hot grant, zero outside GRANT
//   drive_en     : shared driver enable, 1 only in GRANT
//   gnt_id[3]    : index of the current or most recent grantee
//   timeout      : one-cycle pulse in the first TURN cycle when the grant
//                  was ended by the hold limit
//   dbg_state_o  : current FSM state (IDLE=0, GRANT=1, TURN=2)
//
// Request/grant protocol: a branch holds req high for as long as it wants
// the driver. The grant appears one cycle after arbitration in IDLE and is
// withdrawn when the grantee drops req, pulses done, or has held the driver
// for HOLD_MAX cycles.

module load_branch_arbiter #(
    parameter int N_LOADS  = 4,
    parameter int HOLD_MAX = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_LOADS-1:0] req,
    input  logic [N_LOADS-1:0] done,
    output logic [N_LOADS-1:0] gnt,
    output logic               drive_en,
    output logic [2:0]         gnt_id,
    output logic               timeout,
    output logic [1:0]         dbg_state_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] hold_q, hold_d;
    logic [2:0] last_q, last_d;
    logic       timeout_q, timeout_d;

    // Round-robin pick: the lowest requester above last_q wins; if there is
    // none, wrap around to the lowest requester overall. The descending loop
    // leaves the lowest matching index in each candidate.
    logic       hi_found, any_req;
    logic [2:0] hi_id, lo_id, win_id;

    always_comb begin
        hi_found = 1'b0;
        any_req  = 1'b0;
        hi_id    = 3'd0;
        lo_id    = 3'd0;
        for (int j = N_LOADS - 1; j >= 0; j--) begin
            if (req[j]) begin
                any_req = 1'b1;
                lo_id   = 3'(j);
                if (3'(j) > last_q) begin
                    hi_found = 1'b1;
                    hi_id    = 3'(j);
                end
            end
        end
        win_id = hi_found ? hi_id : lo_id;
    end

    // req/done of the current grantee only; other done bits never matter.
    logic req_g, done_g;

    always_comb begin
        req_g  = 1'b0;
        done_g = 1'b0;
        for (int i = 0; i < N_LOADS; i++) begin
            if (last_q == 3'(i)) begin
                req_g  = req[i];
                done_g = done[i];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        last_d    = last_q;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d = GRANT;
                    last_d  = win_id;
                    hold_d  = 4'd1;
                end
            end
            GRANT: begin
                if (done_g || !req_g || (hold_q == 4'(HOLD_MAX))) begin
                    state_d   = TURN;
                    hold_d    = 4'd0;
                    // Only reachable here via the hold limit when the branch
                    // is still requesting and has not released.
                    timeout_d = !done_g && req_g;
                end else if (hold_q != 4'hF) begin
                    hold_d = hold_q + 4'd1;
                end
            end
            TURN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                hold_d  = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            hold_q    <= 4'd0;
            last_q    <= 3'(N_LOADS - 1);
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            last_q    <= last_d;
            timeout_q <= timeout_d;
        end
    end

    // Grant is decoded straight from state, so the asynchronous reset of
    // state_q removes it without waiting for a clock edge.
    always_comb begin
        gnt = '0;
        for (int i = 0; i < N_LOADS; i++) begin
            gnt[i] = (state_q == GRANT) && (last_q == 3'(i));
        end
    end

    assign drive_en    = (state_q == GRANT);
    assign gnt_id      = last_q;
    assign timeout     = timeout_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_load_branch_arbiter.sv
// Bench for load_branch_arbiter: instance A uses defaults (4 loads, hold 8),
// instance B uses 2 loads with hold 1.

module tb_load_branch_arbiter;

    logic       clk;
    logic       rst_a_n, rst_b_n;
    logic [3:0] req_a, done_a, gnt_a;
    logic       de_a, to_a;
    logic [2:0] id_a;
    logic [1:0] st_a;
    logic [1:0] req_b, done_b, gnt_b;
    logic       de_b, to_b;
    logic [2:0] id_b;
    logic [1:0] st_b;

    int checks = 0;
    int passed = 0;

    // Expected record packing: {gnt[3:0], drive_en, timeout, gnt_id[2:0]}
    logic [8:0] exp_q[$];

    typedef struct {
        logic [3:0] req;
        logic [3:0] done;
        logic [3:0] gnt;
        logic       de;
        logic       to;
        logic [2:0] id;
    } vec_t;

    vec_t vecs[26];

    load_branch_arbiter #(.N_LOADS(4), .HOLD_MAX(8)) dut_a (
        .clk        (clk),
        .rst_n      (rst_a_n),
        .req        (req_a),
        .done       (done_a),
        .gnt        (gnt_a),
        .drive_en   (de_a),
        .gnt_id     (id_a),
        .timeout    (to_a),
        .dbg_state_o(st_a)
    );

    load_branch_arbiter #(.N_LOADS(2), .HOLD_MAX(1)) dut_b (
        .clk        (clk),
        .rst_n      (rst_b_n),
        .req        (req_b),
        .done       (done_b),
        .gnt        (gnt_b),
        .drive_en   (de_b),
        .gnt_id     (id_b),
        .timeout    (to_b),
        .dbg_state_o(st_b)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- scoreboard ----------------
    task automatic check_val(input string nm, input logic [8:0] act, input logic [8:0] exp);
        checks++;
        if (act !== exp)
            $display("FAIL %s: got gnt=%b de=%b to=%b id=%0d, want gnt=%b de=%b to=%b id=%0d",
                     nm, act[8:5], act[4], act[3], act[2:0], exp[8:5], exp[4], exp[3], exp[2:0]);
        else
            passed++;
    endtask

    task automatic pop_check(input string nm, input logic [8:0] act);
        logic [8:0] e;
        if (exp_q.size() == 0) begin
            checks++;
            $display("FAIL %s: scoreboard empty, got %b", nm, act);
        end else begin
            e = exp_q.pop_front();
            check_val(nm, act, e);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic step_a(input logic [3:0] r, input logic [3:0] d, input logic [8:0] e, input string nm);
        req_a  = r;
        done_a = d;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        pop_check(nm, {gnt_a, de_a, to_a, id_a});
    endtask

    task automatic step_b(input logic [1:0] r, input logic [8:0] e, input string nm);
        req_b  = r;
        done_b = 2'b00;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        pop_check(nm, {2'b00, gnt_b, de_b, to_b, id_b});
    endtask

    // ---------------- per-cycle invariants ----------------
    logic prev_de_a = 1'b0;
    logic prev_de_b = 1'b0;

    task automatic inv_check(input string nm, input logic [3:0] g, input logic de, input logic to,
                             input logic [2:0] id, input logic pde, input int n);
        logic ok;
        ok = $onehot0(g) && ((g != 4'b0) == de) && (!to || pde) && (int'(id) < n);
        checks++;
        if (!ok)
            $display("FAIL %s: gnt=%b de=%b to=%b prev_de=%b id=%0d violates grant invariants",
                     nm, g, de, to, pde, id);
        else
            passed++;
    endtask

    always @(negedge clk) begin
        inv_check("inv_a", gnt_a, de_a, to_a, id_a, prev_de_a, 4);
        inv_check("inv_b", {2'b00, gnt_b}, de_b, to_b, id_b, prev_de_b, 2);
        prev_de_a <= de_a;
        prev_de_b <= de_b;
    end

    // ---------------- test ----------------
    initial begin
        // Directed table; starts from IDLE with last grantee 0.
        vecs[0]  = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 3'd0}; // no request, stay idle
        vecs[1]  = '{4'b0100, 4'b0000, 4'b0100, 1'b1, 1'b0, 3'd2}; // grant 2, cycle 1
        vecs[2]  = '{4'b0100, 4'b0000, 4'b0100, 1'b1, 1'b0, 3'd2}; // cycle 2
        vecs[3]  = '{4'b0100, 4'b0000, 4'b0100, 1'b1, 1'b0, 3'd2}; // cycle 3
        vecs[4]  = '{4'b0100, 4'b0100, 4'b0000, 1'b0, 1'b0, 3'd2}; // done in cycle 3 -> TURN
        vecs[5]  = '{4'b0100, 4'b0000, 4'b0000, 1'b0, 1'b0, 3'd2}; // IDLE
        vecs[6]  = '{4'b0100, 4'b0000, 4'b0100, 1'b1, 1'b0, 3'd2}; // re-grant 2
        vecs[7]  = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 3'd2}; // req drop -> TURN
        vecs[8]  = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 3'd2}; // IDLE
        vecs[9]  = '{4'b0010, 4'b0001, 4'b0010, 1'b1, 1'b0, 3'd1}; // grant 1, done[0] ignored
        vecs[10] = '{4'b0010, 4'b0001, 4'b0010, 1'b1, 1'b0, 3'd1}; // still held
        vecs[11] = '{4'b1000, 4'b0001, 4'b0000, 1'b0, 1'b0, 3'd1}; // req[1] drops -> TURN
        vecs[12] = '{4'b1000, 4'b0001, 4'b0000, 1'b0, 1'b0, 3'd1}; // IDLE
        vecs[13] = '{4'b1000, 4'b0001, 4'b1000, 1'b1, 1'b0, 3'd3}; // grant 3
        vecs[14] = '{4'b1000, 4'b1000, 4'b0000, 1'b0, 1'b0, 3'd3}; // done[3] -> TURN
        vecs[15] = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 3'd3}; // IDLE
        vecs[16] = '{4'b1010, 4'b0000, 4'b0010, 1'b1, 1'b0, 3'd1}; // wrap from 3: 1 wins
        vecs[17] = '{4'b1010, 4'b0010, 4'b0000, 1'b0, 1'b0, 3'd1}; // release
        vecs[18] = '{4'b1010, 4'b0000, 4'b0000, 1'b0, 1'b0, 3'd1}; // IDLE
        vecs[19] = '{4'b1010, 4'b0000, 4'b1000, 1'b1, 1'b0, 3'd3}; // released 1 lowest: 3 wins
        vecs[20] = '{4'b0010, 4'b0000, 4'b0000, 1'b0, 1'b0, 3'd3}; // req[3] drops
        vecs[21] = '{4'b0010, 4'b0000, 4'b0000, 1'b0, 1'b0, 3'd3}; // IDLE
        vecs[22] = '{4'b0010, 4'b0000, 4'b0010, 1'b1, 1'b0, 3'd1}; // grant 1
        vecs[23] = '{4'b0100, 4'b0010, 4'b0000, 1'b0, 1'b0, 3'd1}; // done[1] -> TURN
        vecs[24] = '{4'b0100, 4'b0000, 4'b0000, 1'b0, 1'b0, 3'd1}; // IDLE
        vecs[25] = '{4'b0100, 4'b0000, 4'b0100, 1'b1, 1'b0, 3'd2}; // grant 2 (reset follows)

        rst_a_n = 1'b0;
        rst_b_n = 1'b0;
        req_a   = 4'b0;
        done_a  = 4'b0;
        req_b   = 2'b0;
        done_b  = 2'b0;

        repeat (3) @(posedge clk);
        #1;
        check_val("reset_a", {gnt_a, de_a, to_a, id_a}, {4'b0000, 1'b0, 1'b0, 3'd3});
        check_val("reset_b", {2'b00, gnt_b, de_b, to_b, id_b}, {4'b0000, 1'b0, 1'b0, 3'd1});

        // Release reset between edges with all branches requesting.
        @(negedge clk);
        rst_a_n = 1'b1;
        req_a   = 4'b1111;
        #1;
        check_val("no_grant_after_release", {gnt_a, de_a, to_a, id_a}, {4'b0000, 1'b0, 1'b0, 3'd3});

        // Full contention: 0,1,2,3,0, each 8 cycles, timeout, 2-cycle gap.
        for (int k = 0; k < 5; k++) begin
            logic [2:0] id;
            logic [3:0] g;
            id = 3'(k % 4);
            g  = 4'(4'b0001 << id);
            for (int c = 0; c < 8; c++)
                step_a(4'b1111, 4'b0000, {g, 1'b1, 1'b0, id}, "rr_grant");
            step_a(4'b1111, 4'b0000, {4'b0000, 1'b0, 1'b1, id}, "rr_timeout_turn");
            step_a(4'b1111, 4'b0000, {4'b0000, 1'b0, 1'b0, id}, "rr_idle");
        end

        for (int v = 0; v < 26; v++)
            step_a(vecs[v].req, vecs[v].done, {vecs[v].gnt, vecs[v].de, vecs[v].to, vecs[v].id},
                   $sformatf("vec%0d", v));

        // Reset mid-grant on branch 2: grant must drop before any clock edge.
        #2;
        rst_a_n = 1'b0;
        #1;
        check_val("async_reset_drop", {gnt_a, de_a, to_a, id_a}, {4'b0000, 1'b0, 1'b0, 3'd3});
        req_a  = 4'b0110;
        done_a = 4'b0000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_a_n = 1'b1;
        #1;
        check_val("post_reset_no_grant", {gnt_a, de_a, to_a, id_a}, {4'b0000, 1'b0, 1'b0, 3'd3});
        step_a(4'b0110, 4'b0000, {4'b0010, 1'b1, 1'b0, 3'd1}, "post_reset_first_grant");
        // Hold to the limit, then release with done in the limit cycle:
        // done wins over timeout.
        for (int c = 0; c < 7; c++)
            step_a(4'b0110, 4'b0000, {4'b0010, 1'b1, 1'b0, 3'd1}, "hold_to_limit");
        step_a(4'b0110, 4'b0010, {4'b0000, 1'b0, 1'b0, 3'd1}, "done_beats_timeout");
        step_a(4'b0110, 4'b0000, {4'b0000, 1'b0, 1'b0, 3'd1}, "idle_after_done");
        step_a(4'b0110, 4'b0000, {4'b0100, 1'b1, 1'b0, 3'd2}, "next_grant_2");
        step_a(4'b0000, 4'b0000, {4'b0000, 1'b0, 1'b0, 3'd2}, "drop_turn");

        // Two loads, hold limit 1: alternating one-cycle grants, period 3.
        @(negedge clk);
        rst_b_n = 1'b1;
        req_b   = 2'b11;
        for (int k = 0; k < 4; k++) begin
            logic [2:0] id;
            logic [1:0] g;
            id = 3'(k % 2);
            g  = 2'(2'b01 << id);
            step_b(2'b11, {2'b00, g, 1'b1, 1'b0, id}, "b_grant");
            step_b(2'b11, {4'b0000, 1'b0, 1'b1, id}, "b_timeout_turn");
            step_b(2'b11, {4'b0000, 1'b0, 1'b0, id}, "b_idle");
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
